// File: rtl/id_hazard_scoreboard.sv
// Decode-stage register hazard / bypass unit built on a per-register pending-writer scoreboard.
// Optional HI/LO tracking is enabled by defining HILO_TRACK_EN.
module id_hazard_scoreboard #(
  parameter int NREGS   = 32,
  parameter int AW      = 5,
  parameter int DW      = 32,
  parameter int NSTAGES = 3,
  parameter int CNT_W   = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         rd_en1,
  input  logic [AW-1:0]                rd_addr1,
  input  logic [DW-1:0]                rf_rdata1,
  input  logic                         rd_en2,
  input  logic [AW-1:0]                rd_addr2,
  input  logic [DW-1:0]                rf_rdata2,
  output logic [DW-1:0]                src_value1,
  output logic [DW-1:0]                src_value2,
  input  logic                         issue_valid,
  input  logic                         issue_go,
  input  logic                         issue_we,
  input  logic [AW-1:0]                issue_dest,
  output logic                         ready_go,
  input  logic [NSTAGES*(2+AW+DW)-1:0] fwd_bus,
  input  logic                         retire_we,
  input  logic [AW-1:0]                retire_addr,
`ifdef HILO_TRACK_EN
  input  logic                         issue_hi_we,
  input  logic                         issue_lo_we,
  input  logic                         rd_hi,
  input  logic                         rd_lo,
  input  logic                         retire_hi_we,
  input  logic                         retire_lo_we,
`endif
  output logic [CNT_W+AW-1:0]          busy_count
);

  localparam int SW = 2 + AW + DW;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]    pend_cnt_q [NREGS];
  logic [CNT_W-1:0]    pend_cnt_d [NREGS];
  logic [CNT_W+AW-1:0] busy_q, busy_d;

  logic          m1, m2, v1, v2;
  logic [DW-1:0] d1, d2;
  logic          haz1, haz2, res1, res2, sat_block, same_retire;

  // Scan oldest to youngest so the youngest matching stage wins.
  always_comb begin
    m1 = 1'b0; v1 = 1'b0; d1 = '0;
    m2 = 1'b0; v2 = 1'b0; d2 = '0;
    for (int s = NSTAGES - 1; s >= 0; s--) begin
      if (fwd_bus[s*SW + DW + AW + 1] && fwd_bus[s*SW + DW +: AW] == rd_addr1) begin
        m1 = 1'b1;
        v1 = fwd_bus[s*SW + DW + AW];
        d1 = fwd_bus[s*SW +: DW];
      end
      if (fwd_bus[s*SW + DW + AW + 1] && fwd_bus[s*SW + DW +: AW] == rd_addr2) begin
        m2 = 1'b1;
        v2 = fwd_bus[s*SW + DW + AW];
        d2 = fwd_bus[s*SW +: DW];
      end
    end
    if (rd_addr1 == '0) m1 = 1'b0;
    if (rd_addr2 == '0) m2 = 1'b0;
  end

  assign src_value1 = m1 ? d1 : rf_rdata1;
  assign src_value2 = m2 ? d2 : rf_rdata2;

  assign haz1 = rd_en1 && (rd_addr1 != '0) && (pend_cnt_q[rd_addr1] != '0);
  assign haz2 = rd_en2 && (rd_addr2 != '0) && (pend_cnt_q[rd_addr2] != '0);
  assign res1 = !haz1 || (m1 && v1);
  assign res2 = !haz2 || (m2 && v2);

  assign same_retire = retire_we && (retire_addr == issue_dest);
  assign sat_block   = issue_we && (issue_dest != '0) &&
                       (pend_cnt_q[issue_dest] == CNT_MAX) && !same_retire;

  // Counters saturate at both ends; a same-cycle issue and retire cancel out.
  always_comb begin
    busy_d = '0;
    pend_cnt_d[0] = '0;
    for (int r = 1; r < NREGS; r++) begin
      logic inc, dec;
      inc = issue_go && issue_we && (issue_dest == AW'(r));
      dec = retire_we && (retire_addr == AW'(r));
      pend_cnt_d[r] = pend_cnt_q[r];
      if (inc && !dec && pend_cnt_q[r] != CNT_MAX) pend_cnt_d[r] = pend_cnt_q[r] + 1'b1;
      if (dec && !inc && pend_cnt_q[r] != '0)      pend_cnt_d[r] = pend_cnt_q[r] - 1'b1;
      if (flush) pend_cnt_d[r] = '0;
      busy_d = busy_d + {{AW{1'b0}}, pend_cnt_d[r]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) pend_cnt_q[r] <= '0;
      busy_q <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) pend_cnt_q[r] <= pend_cnt_d[r];
      busy_q <= busy_d;
    end
  end

  assign busy_count = busy_q;

`ifdef HILO_TRACK_EN
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d, lo_cnt_q, lo_cnt_d;

  always_comb begin
    hi_cnt_d = hi_cnt_q;
    lo_cnt_d = lo_cnt_q;
    if (issue_go && issue_hi_we && !retire_hi_we && hi_cnt_q != CNT_MAX) hi_cnt_d = hi_cnt_q + 1'b1;
    if (retire_hi_we && !(issue_go && issue_hi_we) && hi_cnt_q != '0)    hi_cnt_d = hi_cnt_q - 1'b1;
    if (issue_go && issue_lo_we && !retire_lo_we && lo_cnt_q != CNT_MAX) lo_cnt_d = lo_cnt_q + 1'b1;
    if (retire_lo_we && !(issue_go && issue_lo_we) && lo_cnt_q != '0)    lo_cnt_d = lo_cnt_q - 1'b1;
    if (flush) begin
      hi_cnt_d = '0;
      lo_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_cnt_q <= '0;
      lo_cnt_q <= '0;
    end else begin
      hi_cnt_q <= hi_cnt_d;
      lo_cnt_q <= lo_cnt_d;
    end
  end

  // HI/LO have no bypass path: readers wait until every writer has retired.
  assign ready_go = issue_valid && res1 && res2 && !sat_block &&
                    (!rd_hi || hi_cnt_q == '0) && (!rd_lo || lo_cnt_q == '0);
`else
  assign ready_go = issue_valid && res1 && res2 && !sat_block;
`endif

endmodule

// File: doc/id_hazard_scoreboard.md
Name: id_hazard_scoreboard

Overview:
- Parametrised register-hazard and bypass unit for the decode stage. It replaces per-stage comparator stall/forward logic with a per-register pending-write scoreboard.
- Tracks in-flight GPR writers with counters and picks bypass data from the youngest matching producer stage.
- Generates the decode ready_go.
- Sits between the decode stage, the regfile read ports and the EX/MEM/WB forward buses.

Parameters:
NREGS, 32, number of architectural registers tracked (register 0 never tracked)
AW, 5, register address width, log2(NREGS)
DW, 32, data width
NSTAGES, 3, number of producer stages on fwd_bus; index 0 = youngest (EX)
CNT_W, 2, pending-counter width; max in-flight writers per register = 2^CNT_W-1

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
flush  in  1  clear all pending state (exception/eret)
rd_en1  in  1  source 1 is actually read by the instruction
rd_addr1  in  AW  source 1 register
rf_rdata1  in  DW  regfile data for source 1
rd_en2  in  1  source 2 is actually read
rd_addr2  in  AW  source 2 register
rf_rdata2  in  DW  regfile data for source 2
src_value1  out  DW  resolved source 1 value
src_value2  out  DW  resolved source 2 value
issue_valid  in  1  decode holds a valid instruction
issue_go  in  1  decode instruction transfers to EX this cycle
issue_we  in  1  issuing instruction writes a GPR
issue_dest  in  AW  destination of issuing instruction
ready_go  out  1  decode may advance
fwd_bus  in  NSTAGES*(2+AW+DW)  per stage {we, data_valid, dest, data}; stage 0 in LSBs
retire_we  in  1  WB writes regfile this cycle
retire_addr  in  AW  WB destination
busy_count  out  CNT_W+AW  total in-flight writers (debug/perf)

Behaviour:
- State: pend_cnt[r] for r=1..NREGS-1, CNT_W bits each. Reset and flush clear all counters to 0. busy_count is then 0.
- Increment: at posedge, when issue_go & issue_we & issue_dest!=0, pend_cnt[issue_dest] +1.
- Decrement: at posedge, when retire_we & retire_addr!=0, pend_cnt[retire_addr] -1.
- Same register incremented and decremented in the same cycle: count unchanged.
- flush has priority over issue and retire in the same cycle.
- Decrement of a zero counter never happens legally. The RTL shall hold the counter at 0, and the bench flags it as an error.
- Source hazard for source k:
  - Active when rd_en_k & rd_addr_k!=0 & pend_cnt[rd_addr_k]!=0.
  - Match: search fwd_bus from stage 0 upward and take the first stage with we & dest==rd_addr_k.
  - Source k is resolved when it has no hazard, or when it has a match whose data_valid=1.
  - Source k is stalled when the match has data_valid=0 (e.g. load in EX, div busy), or when no stage matches (producer outside the bus).
- src_value_k = data of the first matching stage if a match exists, else rf_rdata_k. This is purely combinational with zero latency.
- Register 0 always reads rf_rdata (0). No match search is done on it.
- ready_go = issue_valid & src1_resolved & src2_resolved & !sat_block.
  - sat_block = issue_we & issue_dest!=0 & pend_cnt[issue_dest]==max & no same-cycle retire of issue_dest.
- ready_go = 0 after reset with issue_valid low.
- The regfile is assumed write-first: after retire, the value is read from rf_rdata.
- busy_count = sum of all pend_cnt, registered (updated at the same posedge as the counters).

Optional Feature:
- Macro: HILO_TRACK_EN.
- When defined, two extra scoreboard entries track HI and LO. Extra ports:
  - issue_hi_we, issue_lo_we, rd_hi, rd_lo (in, 1 each)
  - retire_hi_we, retire_lo_we (in, 1 each)
- ready_go additionally requires (!rd_hi | hi_cnt==0) & (!rd_lo | lo_cnt==0). HI/LO have no bypass; the instruction stalls until retire.
- When not defined, the ports are absent and HI/LO hazards are the datapath's responsibility.

Test Plan:
- Reset, then issue_valid=1, rd_en1=1, rd_addr1=5, rf_rdata1=0x11 -> ready_go=1, src_value1=0x11, busy_count=0.
- Issue addu r3 (issue_go, issue_dest=3). Next cycle read r3 with EX fwd {we=1, data_valid=1, dest=3, data=0xABCD} -> ready_go=1, src_value1=0xABCD.
- Load to r7 in EX (data_valid=0), consumer reads r7 -> ready_go=0. Next cycle the load is in MEM with data_valid=1, data=0x55 -> ready_go=1, src_value=0x55.
- Two writers to r4 in EX (0x2) and MEM (0x1) -> src_value picks 0x2 from stage 0. pend_cnt[4]=2 drains to 0 after both retire.
- CNT_W=2: three pending writers to r9, fourth issue -> ready_go=0 until a retire of r9. Same-cycle issue+retire of r9 -> count stays 3.
- Pending r6, flush=1 together with issue_go to r6 -> all counters 0 next cycle, busy_count=0, read of r6 uses rf_rdata.
